mask_bbox_tracker: RTL and testbench
====================================

# mask_bbox_tracker

Per-frame object locator fed by the isolated-pixel purification stage in the DE2-115 camera path. It consumes the cleaned 10-bit mask stream and tracks the bounding box, pixel count and sums of coordinates for all foreground pixels in a frame. At frame end, a sequential divider computes the centroid. Results and a one-cycle done pulse go to the overlay/control logic.

## Interface
Parameters:
- IMG_W, 1280: active pixels per line; X range 0..IMG_W-1.
- IMG_H, 960: active lines per frame; Y range 0..IMG_H-1.
- THRESH, 10'd512: a pixel is foreground when iDATA >= THRESH.
- MIN_PIX, 16: minimum foreground count for an object to be reported.

Ports:
- iCLK  in  1  pixel clock.
- iRST_N  in  1  reset, asynchronous, active-low.
- iDATA  in  10  purified mask pixel.
- iDVAL  in  1  qualifies iDATA in the same cycle; low between lines.
- iFVAL  in  1  frame valid; high for the whole active frame.
- oX_MIN, oX_MAX  out  11  bounding box, X.
- oY_MIN, oY_MAX  out  10  bounding box, Y.
- oCX  out  11  centroid X.
- oCY  out  10  centroid Y.
- oCOUNT  out  21  foreground pixel count.
- oOBJ  out  1  last reported frame contained an object (count >= MIN_PIX).
- oDONE  out  1  one-cycle pulse; result outputs are updated in this cycle.
- oBUSY  out  1  divider in progress.

## Operation
- Coordinates:
  - X counter increments on each cycle with iDVAL=1. It clears to 0 on the cycle after the iDVAL falling edge.
  - Y counter increments on each iDVAL falling edge and clears on the iFVAL rising edge.
  - Pixels with x >= IMG_W or y >= IMG_H are ignored.
- Accumulators:
  - Working registers: min/max X/Y, count (21 b), sum_x (32 b), sum_y (32 b).
  - On the iFVAL rising edge: min registers load all-ones, max registers, count and sums load 0.
  - For each qualified foreground pixel: update min/max, count += 1, sum_x += x, sum_y += y.
- Frame end is detected on iFVAL falling, using a registered previous value. At that point the working registers are copied to snapshot registers.
- FSM states IDLE, DIV_X, DIV_Y, DONE:
  - IDLE to DIV_X on frame end with snapshot count >= MIN_PIX.
  - IDLE to DONE on frame end with count < MIN_PIX.
  - DIV_X: 32-cycle restoring divide, sum_x / count, then go to DIV_Y.
  - DIV_Y: 32-cycle divide, sum_y / count, then go to DONE.
  - DONE: one cycle, then go to IDLE.
- Division is unsigned with truncating quotient. The quotient is taken from the low 11 bits for X and the low 10 bits for Y.
- In DONE:
  - oDONE=1.
  - If an object was found: outputs load the snapshot bbox, quotients and count, and oOBJ=1.
  - If no object: all result outputs load 0 and oOBJ=0.
- Result outputs hold between DONE cycles.
- Accumulation runs independently of the divider, so a new frame accumulates while the previous one divides.
- A frame end arriving while the FSM is not in IDLE is dropped: no snapshot, no oDONE, and the in-flight result is unaffected.
- oBUSY=1 in DIV_X and DIV_Y.

## Timing
- Reset values: all outputs 0, FSM IDLE, counters and accumulators 0, edge-detect registers 0.
- Cycle 0 is the first cycle with iFVAL=0 after iFVAL=1.
  - Object path: DIV_X covers cycles 1..32, DIV_Y covers 33..64, oDONE at cycle 65.
  - No-object path: oDONE at cycle 1.
- The accumulator update for a pixel is registered one cycle after that pixel is presented.
- A foreground pixel in the last cycle before iFVAL falls is included in the snapshot.
- A reset asserted mid-division returns everything to reset values immediately. No oDONE is issued for the aborted frame.
- iDVAL=1 with iFVAL=0 is ignored.

## Test plan
- Single-pixel frame, MIN_PIX=1, pixel 10'd1020 at (10,5) -> oOBJ=1, bbox 10/10/5/5, oCX=10, oCY=5, oCOUNT=1, oDONE at cycle 65.
- 4x4 block at x=100..103, y=50..53, MIN_PIX=16:
  - Expect oCOUNT=16, oX_MIN=100, oX_MAX=103, oY_MIN=50, oY_MAX=53.
  - Expect oCX=101 (1624/16 truncated) and oCY=51.
- Threshold and empty frame:
  - Frame of iDATA=THRESH-1 everywhere -> oOBJ=0, all results 0, oDONE at cycle 1.
  - Same frame with one pixel at THRESH, MIN_PIX=1 -> oCOUNT=1.
- Second frame ends 20 cycles after the first frame end (divider busy) -> exactly one oDONE, carrying the first frame's results. Next frame end after IDLE is processed normally.
- iRST_N low at cycle 40 of a division -> all outputs 0 and FSM in IDLE. The following full frame reports correctly.
- Pixel at x=IMG_W (extra iDVAL cycle) and on line y=IMG_H -> not counted; bbox unchanged.

Source files
------------

// File: rtl/mask_bbox_tracker.sv
`timescale 1ns/1ps
// mask_bbox_tracker
// Locates the foreground object in each frame of the purified mask stream.
// While a frame streams in, it tracks the bounding box, the pixel count and
// the coordinate sums. At frame end these are frozen into snapshot registers.
// A shared restoring divider then computes the centroid (sum / count) for X
// and then Y. The next frame can accumulate while the previous one divides.
module mask_bbox_tracker #(
    parameter int         IMG_W   = 1280,
    parameter int         IMG_H   = 960,
    parameter logic [9:0] THRESH  = 10'd512,
    parameter int         MIN_PIX = 16
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [9:0]  iDATA,
    input  logic        iDVAL,
    input  logic        iFVAL,
    output logic [10:0] oX_MIN,
    output logic [10:0] oX_MAX,
    output logic [9:0]  oY_MIN,
    output logic [9:0]  oY_MAX,
    output logic [10:0] oCX,
    output logic [9:0]  oCY,
    output logic [20:0] oCOUNT,
    output logic        oOBJ,
    output logic        oDONE,
    output logic        oBUSY
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIV_X = 2'd1,
        S_DIV_Y = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // One restoring-division step: shift the next dividend bit into the
    // remainder and subtract the divisor if it fits. The remainder is always
    // below the divisor, so the trial value fits in 22 bits and bit 21 of the
    // difference is set exactly when the divisor does not fit.
    // Result packing: {remainder[20:0], quotient[31:0]}.
    function automatic logic [52:0] div_step(input logic [20:0] rem,
                                              input logic [31:0] quo,
                                              input logic [20:0] divisor);
        logic [21:0] trial;
        logic [21:0] diff;
        logic        qbit;
        trial = {rem, quo[31]};
        diff  = trial - {1'b0, divisor};
        qbit  = ~diff[21];
        return {(qbit ? diff[20:0] : trial[20:0]), quo[30:0], qbit};
    endfunction

    // Edge detection and stream qualification
    logic        fval_r;
    logic        dval_r;
    logic        dval_s;
    logic        fval_rise_s;
    logic        fval_fall_s;
    logic        dval_fall_s;

    // Pixel coordinates (one spare bit so out-of-range pixels can be seen)
    logic [11:0] x_cnt_r;
    logic [10:0] y_cnt_r;
    logic        fg_s;

    // Working accumulators for the frame being received
    logic [10:0] xmin_r;
    logic [10:0] xmax_r;
    logic [9:0]  ymin_r;
    logic [9:0]  ymax_r;
    logic [20:0] cnt_r;
    logic [31:0] sumx_r;
    logic [31:0] sumy_r;

    // Snapshot of the frame being divided
    logic [10:0] snap_xmin_r;
    logic [10:0] snap_xmax_r;
    logic [9:0]  snap_ymin_r;
    logic [9:0]  snap_ymax_r;
    logic [20:0] snap_cnt_r;
    logic [31:0] snap_sumy_r;

    // Control and divider
    state_t      state_r;
    state_t      state_nxt_s;
    logic        obj_s;
    logic        accept_s;
    logic [4:0]  div_cnt_r;
    logic [20:0] rem_r;
    logic [31:0] quo_r;
    logic [10:0] cx_r;
    logic [52:0] step_s;

    // Data valid only counts inside a frame; stray iDVAL outside is ignored.
    assign dval_s      = iDVAL & iFVAL;
    assign fval_rise_s = iFVAL & ~fval_r;
    assign fval_fall_s = ~iFVAL & fval_r;
    assign dval_fall_s = ~dval_s & dval_r;
    assign fg_s        = dval_s && (iDATA >= THRESH)
                         && (x_cnt_r < 12'(IMG_W)) && (y_cnt_r < 11'(IMG_H));
    assign obj_s       = (cnt_r >= 21'(MIN_PIX));
    assign accept_s    = fval_fall_s && (state_r == S_IDLE);
    assign step_s      = div_step(rem_r, quo_r, snap_cnt_r);

    // Previous-cycle copies of the qualified valids for edge detection
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            fval_r <= 1'b0;
            dval_r <= 1'b0;
        end else begin
            fval_r <= iFVAL;
            dval_r <= dval_s;
        end
    end

    // X counts pixels within a line, Y counts completed lines within a frame
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            x_cnt_r <= 12'd0;
            y_cnt_r <= 11'd0;
        end else begin
            if (dval_fall_s) begin
                x_cnt_r <= 12'd0;
            end else if (dval_s) begin
                x_cnt_r <= x_cnt_r + 12'd1;
            end
            if (fval_rise_s) begin
                y_cnt_r <= 11'd0;
            end else if (dval_fall_s) begin
                y_cnt_r <= y_cnt_r + 11'd1;
            end
        end
    end

    // Working accumulators: cleared at frame start, updated per foreground pixel
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            xmin_r <= 11'd0;
            xmax_r <= 11'd0;
            ymin_r <= 10'd0;
            ymax_r <= 10'd0;
            cnt_r  <= 21'd0;
            sumx_r <= 32'd0;
            sumy_r <= 32'd0;
        end else if (fval_rise_s) begin
            xmin_r <= 11'h7FF;
            xmax_r <= 11'd0;
            ymin_r <= 10'h3FF;
            ymax_r <= 10'd0;
            cnt_r  <= 21'd0;
            sumx_r <= 32'd0;
            sumy_r <= 32'd0;
        end else if (fg_s) begin
            if (x_cnt_r[10:0] < xmin_r) xmin_r <= x_cnt_r[10:0];
            if (x_cnt_r[10:0] > xmax_r) xmax_r <= x_cnt_r[10:0];
            if (y_cnt_r[9:0] < ymin_r)  ymin_r <= y_cnt_r[9:0];
            if (y_cnt_r[9:0] > ymax_r)  ymax_r <= y_cnt_r[9:0];
            cnt_r  <= cnt_r + 21'd1;
            sumx_r <= sumx_r + {20'd0, x_cnt_r};
            sumy_r <= sumy_r + {21'd0, y_cnt_r};
        end
    end

    // Freeze the working set at an accepted frame end
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            snap_xmin_r <= 11'd0;
            snap_xmax_r <= 11'd0;
            snap_ymin_r <= 10'd0;
            snap_ymax_r <= 10'd0;
            snap_cnt_r  <= 21'd0;
            snap_sumy_r <= 32'd0;
        end else if (accept_s) begin
            snap_xmin_r <= xmin_r;
            snap_xmax_r <= xmax_r;
            snap_ymin_r <= ymin_r;
            snap_ymax_r <= ymax_r;
            snap_cnt_r  <= cnt_r;
            snap_sumy_r <= sumy_r;
        end
    end

    // FSM state register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: frame ends outside IDLE are simply not seen
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (fval_fall_s) begin
                    state_nxt_s = obj_s ? S_DIV_X : S_DONE;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_DIV_X: begin
                if (div_cnt_r == 5'd31) begin
                    state_nxt_s = S_DIV_Y;
                end else begin
                    state_nxt_s = S_DIV_X;
                end
            end
            S_DIV_Y: begin
                if (div_cnt_r == 5'd31) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_DIV_Y;
                end
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Divider datapath: sum_x is loaded as the dividend at frame end, sum_y
    // is reloaded as X finishes; the X quotient is parked in cx_r
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            div_cnt_r <= 5'd0;
            rem_r     <= 21'd0;
            quo_r     <= 32'd0;
            cx_r      <= 11'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    div_cnt_r <= 5'd0;
                    if (fval_fall_s && obj_s) begin
                        quo_r <= sumx_r;
                        rem_r <= 21'd0;
                    end
                end
                S_DIV_X: begin
                    div_cnt_r <= div_cnt_r + 5'd1;
                    if (div_cnt_r == 5'd31) begin
                        cx_r  <= step_s[10:0];
                        quo_r <= snap_sumy_r;
                        rem_r <= 21'd0;
                    end else begin
                        quo_r <= step_s[31:0];
                        rem_r <= step_s[52:32];
                    end
                end
                S_DIV_Y: begin
                    div_cnt_r <= div_cnt_r + 5'd1;
                    quo_r     <= step_s[31:0];
                    rem_r     <= step_s[52:32];
                end
                default: begin
                    div_cnt_r <= 5'd0;
                end
            endcase
        end
    end

    // Registered results: loaded on entry to DONE, held otherwise
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oX_MIN <= 11'd0;
            oX_MAX <= 11'd0;
            oY_MIN <= 10'd0;
            oY_MAX <= 10'd0;
            oCX    <= 11'd0;
            oCY    <= 10'd0;
            oCOUNT <= 21'd0;
            oOBJ   <= 1'b0;
            oDONE  <= 1'b0;
            oBUSY  <= 1'b0;
        end else begin
            oDONE <= (state_nxt_s == S_DONE);
            oBUSY <= (state_nxt_s == S_DIV_X) || (state_nxt_s == S_DIV_Y);
            if ((state_r == S_DIV_Y) && (div_cnt_r == 5'd31)) begin
                oX_MIN <= snap_xmin_r;
                oX_MAX <= snap_xmax_r;
                oY_MIN <= snap_ymin_r;
                oY_MAX <= snap_ymax_r;
                oCX    <= cx_r;
                oCY    <= step_s[9:0];
                oCOUNT <= snap_cnt_r;
                oOBJ   <= 1'b1;
            end else if (accept_s && !obj_s) begin
                oX_MIN <= 11'd0;
                oX_MAX <= 11'd0;
                oY_MIN <= 10'd0;
                oY_MAX <= 10'd0;
                oCX    <= 11'd0;
                oCY    <= 10'd0;
                oCOUNT <= 21'd0;
                oOBJ   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mask_bbox_tracker.sv
`timescale 1ns/1ps
// Bench for mask_bbox_tracker: two instances share one stream, one reporting
// any object (MIN_PIX=1) and one needing 16 pixels. A reduced image size keeps
// frames short. Directed frames come from a table, random frames are scored
// against a pixel-loop reference model.
module tb_mask_bbox_tracker;

    localparam int W = 120;
    localparam int H = 56;

    typedef struct {
        logic [31:0] cnt, xmin, xmax, ymin, ymax, cx, cy;
        logic        obj;
    } res_t;

    typedef struct {
        int   nl, np;
        bit   tail;
        int   bg, rx, ry, rw, rh, rv, ex, ey, ev;
        res_t exp;
    } vec_t;

    logic        iCLK, iRST_N, iDVAL, iFVAL;
    logic [9:0]  iDATA;
    logic [10:0] a_xmin, a_xmax, a_cx, b_xmin, b_xmax, b_cx;
    logic [9:0]  a_ymin, a_ymax, a_cy, b_ymin, b_ymax, b_cy;
    logic [20:0] a_cnt, b_cnt;
    logic        a_obj, a_done, a_busy, b_obj, b_done, b_busy;

    logic [9:0]  img [0:59][0:127];
    int          cyc = 0;
    int          fe_cyc = 0;
    int          done_n [2] = '{0, 0};
    int          done_at [2] = '{0, 0};
    int          checks = 0;
    int          failures = 0;
    vec_t        tbl [8];

    mask_bbox_tracker #(.IMG_W(W), .IMG_H(H), .THRESH(10'd512), .MIN_PIX(1)) dut_a (
        .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(iDATA), .iDVAL(iDVAL), .iFVAL(iFVAL),
        .oX_MIN(a_xmin), .oX_MAX(a_xmax), .oY_MIN(a_ymin), .oY_MAX(a_ymax),
        .oCX(a_cx), .oCY(a_cy), .oCOUNT(a_cnt), .oOBJ(a_obj), .oDONE(a_done), .oBUSY(a_busy));

    mask_bbox_tracker #(.IMG_W(W), .IMG_H(H), .THRESH(10'd512), .MIN_PIX(16)) dut_b (
        .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(iDATA), .iDVAL(iDVAL), .iFVAL(iFVAL),
        .oX_MIN(b_xmin), .oX_MAX(b_xmax), .oY_MIN(b_ymin), .oY_MAX(b_ymax),
        .oCX(b_cx), .oCY(b_cy), .oCOUNT(b_cnt), .oOBJ(b_obj), .oDONE(b_done), .oBUSY(b_busy));

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) cyc <= cyc + 1;

    always @(negedge iCLK) begin
        if (a_done === 1'b1) begin
            done_n[0]  <= done_n[0] + 1;
            done_at[0] <= cyc;
        end
        if (b_done === 1'b1) begin
            done_n[1]  <= done_n[1] + 1;
            done_at[1] <= cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(int nl, int np, bit tail, int bg, int rx, int ry, int rw,
                                 int rh, int rv, int ex, int ey, int ev, int cnt, int xmin,
                                 int xmax, int ymin, int ymax, int cx, int cy, bit obj);
        vec_t v;
        v.nl = nl; v.np = np; v.tail = tail; v.bg = bg;
        v.rx = rx; v.ry = ry; v.rw = rw; v.rh = rh; v.rv = rv;
        v.ex = ex; v.ey = ey; v.ev = ev;
        v.exp.cnt = cnt; v.exp.xmin = xmin; v.exp.xmax = xmax;
        v.exp.ymin = ymin; v.exp.ymax = ymax; v.exp.cx = cx; v.exp.cy = cy;
        v.exp.obj = obj;
        return v;
    endfunction

    function automatic res_t gate16(res_t e);
        res_t z = '{default: '0};
        return (e.cnt >= 16) ? e : z;
    endfunction

    // Reference: scan the image the way the spec defines the frame
    function automatic res_t model(int nl, int np, int minp);
        res_t r = '{default: '0};
        int   cnt = 0, xmin = 99999, xmax = 0, ymin = 99999, ymax = 0;
        longint sx = 0, sy = 0;
        for (int y = 0; y < nl; y++)
            for (int x = 0; x < np; x++)
                if (x < W && y < H && img[y][x] >= 10'd512) begin
                    cnt++; sx += x; sy += y;
                    if (x < xmin) xmin = x;
                    if (x > xmax) xmax = x;
                    if (y < ymin) ymin = y;
                    if (y > ymax) ymax = y;
                end
        if (cnt >= minp) begin
            r.obj = 1'b1; r.cnt = cnt;
            r.xmin = xmin; r.xmax = xmax; r.ymin = ymin; r.ymax = ymax;
            r.cx = 32'((sx / cnt) % 2048);
            r.cy = 32'((sy / cnt) % 1024);
        end
        return r;
    endfunction

    task automatic fill(int v);
        for (int y = 0; y < 60; y++)
            for (int x = 0; x < 128; x++)
                img[y][x] = 10'(v);
    endtask

    task automatic render(input vec_t v);
        fill(v.bg);
        for (int y = v.ry; y < v.ry + v.rh; y++)
            for (int x = v.rx; x < v.rx + v.rw; x++)
                img[y][x] = 10'(v.rv);
        if (v.ex >= 0) img[v.ey][v.ex] = 10'(v.ev);
    endtask

    // Drive one frame; fe_cyc marks the first cycle with iFVAL low (cycle 0)
    task automatic send_frame(int nl, int np, bit tail);
        @(negedge iCLK); iFVAL = 1'b1;
        @(negedge iCLK);
        @(negedge iCLK);
        for (int y = 0; y < nl; y++) begin
            for (int x = 0; x < np; x++) begin
                iDVAL = 1'b1; iDATA = img[y][x];
                @(negedge iCLK);
            end
            iDVAL = 1'b0; iDATA = 10'd0;
            if (tail || y != nl - 1) begin
                @(negedge iCLK);
                @(negedge iCLK);
            end
        end
        iFVAL = 1'b0;
        fe_cyc = cyc;
        @(negedge iCLK);
    endtask

    task automatic check_out(input string tag, input int d, input res_t e);
        chk({tag, ".cnt"},  d ? 32'(b_cnt)  : 32'(a_cnt),  e.cnt);
        chk({tag, ".xmin"}, d ? 32'(b_xmin) : 32'(a_xmin), e.xmin);
        chk({tag, ".xmax"}, d ? 32'(b_xmax) : 32'(a_xmax), e.xmax);
        chk({tag, ".ymin"}, d ? 32'(b_ymin) : 32'(a_ymin), e.ymin);
        chk({tag, ".ymax"}, d ? 32'(b_ymax) : 32'(a_ymax), e.ymax);
        chk({tag, ".cx"},   d ? 32'(b_cx)   : 32'(a_cx),   e.cx);
        chk({tag, ".cy"},   d ? 32'(b_cy)   : 32'(a_cy),   e.cy);
        chk({tag, ".obj"},  d ? 32'(b_obj)  : 32'(a_obj),  32'(e.obj));
    endtask

    task automatic check_done(input string tag, input int d, input int base,
                              input int c0, input res_t e);
        chk({tag, ".ndone"}, done_n[d] - base, 1);
        chk({tag, ".lat"},   done_at[d] - c0, e.obj ? 65 : 1);
        chk({tag, ".busy"},  d ? 32'(b_busy) : 32'(a_busy), 0);
        check_out(tag, d, e);
    endtask

    task automatic run_frame(input string tag, input int nl, input int np, input bit tail,
                             input res_t e1, input res_t e16);
        int b0 = done_n[0];
        int b1 = done_n[1];
        int c0;
        send_frame(nl, np, tail);
        c0 = fe_cyc;
        repeat (80) @(negedge iCLK);
        check_done({tag, ".m1"}, 0, b0, c0, e1);
        check_done({tag, ".m16"}, 1, b1, c0, e16);
    endtask

    task automatic check_zero(input string tag);
        res_t z = '{default: '0};
        for (int d = 0; d < 2; d++) begin
            check_out($sformatf("%s.d%0d", tag, d), d, z);
            chk({tag, ".done"}, d ? 32'(b_done) : 32'(a_done), 0);
            chk({tag, ".busy"}, d ? 32'(b_busy) : 32'(a_busy), 0);
        end
    endtask

    initial begin
        res_t e1, e16;
        int   b0, b1, ca, nl, np;
        bit   tail;

        //          nl  np  t  bg  rx  ry rw rh rv    ex  ey  ev   cnt xmin xmax ymin ymax cx  cy obj
        tbl[0] = mkv(6, 12, 1, 0,  10, 5, 1, 1, 1020, -1, 0,  0,   1,  10,  10,  5,   5,   10, 5, 1);
        tbl[1] = mkv(54,104,1, 0,  100,50,4, 4, 600,  -1, 0,  0,   16, 100, 103, 50,  53,  101,51,1);
        tbl[2] = mkv(8, 16, 1, 511, 0, 0, 0, 0, 0,    -1, 0,  0,   0,  0,   0,   0,   0,   0,  0, 0);
        tbl[3] = mkv(8, 16, 1, 511, 3, 2, 1, 1, 512,  -1, 0,  0,   1,  3,   3,   2,   2,   3,  2, 1);
        tbl[4] = mkv(3, 121,1, 0,  5,  1, 1, 1, 900,  120,1,  900, 1,  5,   5,   1,   1,   5,  1, 1);
        tbl[5] = mkv(57,8,  1, 0,  2,  3, 1, 1, 700,  4,  56, 700, 1,  2,   2,   3,   3,   2,  3, 1);
        tbl[6] = mkv(5, 8,  1, 0,  1,  1, 5, 3, 1023, -1, 0,  0,   15, 1,   5,   1,   3,   3,  2, 1);
        tbl[7] = mkv(4, 9,  0, 0,  0,  0, 1, 1, 800,  8,  3,  800, 2,  0,   8,   0,   3,   4,  1, 1);

        iRST_N = 1'b0; iFVAL = 1'b0; iDVAL = 1'b0; iDATA = 10'd0;
        repeat (3) @(negedge iCLK);
        check_zero("reset");
        iRST_N = 1'b1;
        @(negedge iCLK);

        for (int i = 0; i < 8; i++) begin
            render(tbl[i]);
            run_frame($sformatf("vec%0d", i), tbl[i].nl, tbl[i].np, tbl[i].tail,
                      tbl[i].exp, gate16(tbl[i].exp));
        end

        for (int k = 0; k < 8; k++) begin
            for (int y = 0; y < 60; y++)
                for (int x = 0; x < 128; x++)
                    img[y][x] = 10'($urandom_range(0, 1023));
            nl   = $urandom_range(1, 8);
            np   = ($urandom_range(0, 3) == 0) ? 122 : $urandom_range(1, 24);
            tail = 1'($urandom_range(0, 1));
            run_frame($sformatf("rnd%0d", k), nl, np, tail, model(nl, np, 1), model(nl, np, 16));
        end

        // Second frame ends 20 cycles into the first frame's division
        fill(0);
        for (int y = 1; y < 5; y++)
            for (int x = 2; x < 6; x++)
                img[y][x] = 10'd1000;
        e1 = model(5, 8, 1);
        e16 = model(5, 8, 16);
        b0 = done_n[0];
        b1 = done_n[1];
        send_frame(5, 8, 1);
        ca = fe_cyc;
        fill(0);
        img[0][13] = 10'd1023;
        send_frame(1, 14, 1);
        repeat (120) @(negedge iCLK);
        check_done("ovl.m1", 0, b0, ca, e1);
        check_done("ovl.m16", 1, b1, ca, e16);
        render(tbl[0]);
        run_frame("after_ovl", tbl[0].nl, tbl[0].np, tbl[0].tail, tbl[0].exp, gate16(tbl[0].exp));

        // Reset in the middle of a division
        fill(0);
        for (int y = 2; y < 6; y++)
            for (int x = 3; x < 7; x++)
                img[y][x] = 10'd700;
        b0 = done_n[0];
        b1 = done_n[1];
        send_frame(6, 9, 1);
        ca = fe_cyc;
        while (cyc < ca + 40) @(negedge iCLK);
        iRST_N = 1'b0;
        @(negedge iCLK);
        check_zero("midrst");
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (100) @(negedge iCLK);
        chk("midrst.nodone_m1", done_n[0] - b0, 0);
        chk("midrst.nodone_m16", done_n[1] - b1, 0);
        render(tbl[6]);
        run_frame("after_rst", tbl[6].nl, tbl[6].np, tbl[6].tail, tbl[6].exp, gate16(tbl[6].exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
